// File: rtl/mul_acc_pipe_if.sv
// mul_acc_pipe_if: operand/result stream bundle for mul_acc_pipe.
interface mul_acc_pipe_if #(
    parameter int A_W   = 16,
    parameter int B_W   = 16,
    parameter int ACC_W = 40
);
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   a_in;
    logic [B_W-1:0]   b_in;
    logic             is_signed;
    logic             accumulate;
    logic             last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result_out;
    logic             overflow;
    modport master (
        output in_valid, a_in, b_in, is_signed, accumulate, last, out_ready,
        input  in_ready, out_valid, result_out, overflow
    );
    modport slave (
        input  in_valid, a_in, b_in, is_signed, accumulate, last, out_ready,
        output in_ready, out_valid, result_out, overflow
    );
endinterface

// File: rtl/mul_acc_pipe.sv
// mul_acc_pipe: pipelined multiply-accumulate with valid/ready backpressure.
// Define MAC_SAT_EN to saturate accumulation and report overflow; otherwise sums wrap.
module mul_acc_pipe #(
    parameter int A_W   = 16,
    parameter int B_W   = 16,
    parameter int PIPE  = 1,
    parameter int ACC_W = 40
) (
    input logic           clk,
    input logic           reset,
    mul_acc_pipe_if.slave bus
);
    typedef struct packed {
        logic             v;
        logic             sg;
        logic             ac;
        logic             ls;
        logic [ACC_W-1:0] p;
    } stage_t;

    logic                      stall;
    logic                      op_v, op_sg, op_ac, op_ls;
    logic [A_W-1:0]            op_a;
    logic [B_W-1:0]            op_b;
    logic signed [A_W:0]       ax;
    logic signed [B_W:0]       bx;
    logic signed [A_W+B_W+1:0] full;
    stage_t                    head, tail;
    logic [ACC_W-1:0]          acc, sum;
    logic                      emit;

    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;

    always_ff @(posedge clk or posedge reset)
        if (reset)
            {op_v, op_sg, op_ac, op_ls, op_a, op_b} <= '0;
        else if (!stall)
            {op_v, op_sg, op_ac, op_ls, op_a, op_b} <=
                {bus.in_valid, bus.is_signed, bus.accumulate, bus.last, bus.a_in, bus.b_in};

    // One extra operand bit lets a single signed multiplier serve both modes;
    // the exact product then sign/zero-extends correctly through the cast.
    assign ax   = {op_sg & op_a[A_W-1], op_a};
    assign bx   = {op_sg & op_b[B_W-1], op_b};
    assign full = ax * bx;
    assign head = {op_v, op_sg, op_ac, op_ls, ACC_W'(full)};

    if (PIPE == 1) begin : g_direct
        assign tail = head;
    end else begin : g_delay
        stage_t d [PIPE-1];
        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                for (int i = 0; i < PIPE-1; i++) d[i] <= '0;
            end else if (!stall) begin
                d[0] <= head;
                for (int i = 1; i < PIPE-1; i++) d[i] <= d[i-1];
            end
        assign tail = d[PIPE-2];
    end

`ifdef MAC_SAT_EN
    localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    logic [ACC_W:0] wide;
    logic           step_ovf, sticky, ovf_q;
    always_comb begin
        wide     = {1'b0, acc} + {1'b0, tail.p};
        step_ovf = tail.sg ? (acc[ACC_W-1] == tail.p[ACC_W-1]) && (wide[ACC_W-1] != acc[ACC_W-1])
                           : wide[ACC_W];
        sum      = !step_ovf ? wide[ACC_W-1:0] : !tail.sg ? '1 : acc[ACC_W-1] ? ~S_MAX : S_MAX;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sticky <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (!stall) begin
            if (emit) ovf_q <= tail.ac && (sticky || step_ovf);
            if (tail.v && tail.ac) sticky <= !tail.ls && (sticky || step_ovf);
        end
    assign bus.overflow = ovf_q;
`else
    assign sum          = acc + tail.p;
    assign bus.overflow = 1'b0;
`endif

    // Only plain products and closing accumulate beats produce a result.
    assign emit = tail.v && (!tail.ac || tail.ls);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            acc            <= '0;
            bus.out_valid  <= 1'b0;
            bus.result_out <= '0;
        end else if (!stall) begin
            bus.out_valid <= emit;
            if (emit) bus.result_out <= tail.ac ? sum : tail.p;
            if (tail.v && tail.ac) acc <= tail.ls ? '0 : sum;
        end
endmodule

// File: tb/tb_mul_acc_pipe.sv
// tb_mul_acc_pipe: vector table, directed corner sequences and a randomized
// scoreboard against an arithmetic reference model for mul_acc_pipe (PIPE=3).
module tb_mul_acc_pipe;
    localparam int A_W = 16, B_W = 16, PIPE = 3, ACC_W = 40;
    localparam longint MAXS = (longint'(1) << (ACC_W-1)) - 1;
    localparam longint MINS = -(longint'(1) << (ACC_W-1));
    localparam longint MAXU = (longint'(1) << ACC_W) - 1;

    typedef struct {
        logic [ACC_W-1:0] r;
        logic             o;
    } res_t;
    typedef struct {
        logic [15:0]      a, b;
        logic             sg, ac, ls;
        logic [ACC_W-1:0] r;
        logic             o;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0, errors = 0, consumed = 0, mode = 0, cyc = 0;
    logic [3:0] pat = 4'b1001;
    logic [ACC_W-1:0] m_acc = '0;
    logic m_ovf = 1'b0;
    res_t exp_q[$];
    res_t mon_e;
    logic prev_stall = 1'b0, prev_o;
    logic [ACC_W-1:0] prev_r;

    always #5 clk = ~clk;

    mul_acc_pipe_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) bus ();
    mul_acc_pipe #(.A_W(A_W), .B_W(B_W), .PIPE(PIPE), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: exact integer sum per beat, then wrap or clamp to the accumulator range.
    task automatic model(input logic [15:0] a, b, input logic sg, ac, ls);
        longint p, t;
        logic o;
        p = sg ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
        if (!ac) begin
            exp_q.push_back(res_t'{r: p[ACC_W-1:0], o: 1'b0});
            return;
        end
        t = sg ? longint'($signed(m_acc)) + p : longint'(m_acc) + p;
        o = 1'b0;
`ifdef MAC_SAT_EN
        if (sg && t > MAXS) begin t = MAXS; o = 1'b1; end
        else if (sg && t < MINS) begin t = MINS; o = 1'b1; end
        else if (!sg && t > MAXU) begin t = MAXU; o = 1'b1; end
`endif
        m_ovf = m_ovf | o;
        if (ls) begin
            exp_q.push_back(res_t'{r: t[ACC_W-1:0], o: m_ovf});
            m_acc = '0;
            m_ovf = 1'b0;
        end else m_acc = t[ACC_W-1:0];
    endtask

    task automatic send(input logic [15:0] a, b, input logic sg, ac, ls);
        logic acc_ok;
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.a_in = a; bus.b_in = b;
        bus.is_signed = sg; bus.accumulate = ac; bus.last = ls;
        n = 0;
        forever begin
            #1 acc_ok = bus.in_ready;
            @(posedge clk);
            if (acc_ok) break;
            if (++n > 200) begin
                check("accept_timeout", 64'(n), 0);
                break;
            end
            @(negedge clk);
        end
        if (acc_ok) model(a, b, sg, ac, ls);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 2000) begin
            @(negedge clk);
            #1 n++;
        end
        check("drain_empty", 64'(exp_q.size()), 0);
    endtask

    always @(negedge clk) begin
        cyc++;
        bus.out_ready = mode == 0 ? 1'b1 : mode == 1 ? pat[cyc % 4] : 1'($urandom);
    end

    // Scoreboard: compare each consumed result in order; also check handshake rules.
    always @(negedge clk) begin
        #1;
        if (reset) prev_stall = 1'b0;
        else begin
            check("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (prev_stall) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_result", bus.result_out, prev_r);
                check("stall_ovf", bus.overflow, prev_o);
            end
            if (bus.out_valid && bus.out_ready) begin
                consumed++;
                if (exp_q.size() == 0) check("unexpected_result", bus.result_out, 64'hDEAD);
                else begin
                    mon_e = exp_q.pop_front();
                    check("sb_result", bus.result_out, mon_e.r);
                    check("sb_ovf", bus.overflow, mon_e.o);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_r = bus.result_out;
            prev_o = bus.overflow;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[10];
        int k, c0;
        logic [ACC_W-1:0] sat_r;
        logic sat_o;
        tbl[0] = '{16'hFFFF, 16'hFFFF, 0, 0, 0, 40'h00FFFE0001, 0};
        tbl[1] = '{16'hFFFD, 16'h0005, 1, 0, 0, 40'hFFFFFFFFF1, 0};
        tbl[2] = '{16'd100, 16'd200, 0, 1, 0, 40'h0, 0};
        tbl[3] = '{16'd100, 16'd200, 0, 1, 0, 40'h0, 0};
        tbl[4] = '{16'd100, 16'd200, 0, 1, 0, 40'h0, 0};
        tbl[5] = '{16'd100, 16'd200, 0, 1, 1, 40'h13880, 0};
        tbl[6] = '{16'd2, 16'd3, 0, 0, 0, 40'h6, 0};
        tbl[7] = '{16'h8000, 16'h8000, 0, 0, 0, 40'h0040000000, 0};
        tbl[8] = '{16'hFFFF, 16'h0001, 1, 0, 1, 40'hFFFFFFFFFF, 0};
        tbl[9] = '{16'h7FFF, 16'h8000, 1, 0, 0, 40'hFFC0008000, 0};
`ifdef MAC_SAT_EN
        sat_r = 40'h7FFFFFFFFF; sat_o = 1'b1;
`else
        sat_r = 40'h8000000000; sat_o = 1'b0;
`endif
        bus.in_valid = 1'b0; bus.a_in = '0; bus.b_in = '0;
        bus.is_signed = 1'b0; bus.accumulate = 1'b0; bus.last = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_valid", bus.out_valid, 0);
        check("reset_result", bus.result_out, 0);
        check("reset_ovf", bus.overflow, 0);
        reset = 1'b0;
        #1 check("reset_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 10; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].sg, tbl[i].ac, tbl[i].ls);
            if (!tbl[i].ac || tbl[i].ls) begin
                k = 0;
                do begin
                    @(posedge clk);
                    k++;
                    @(negedge clk);
                    #1;
                end while (!bus.out_valid && k < PIPE + 4);
                check($sformatf("vec%0d_latency", i), 64'(k), PIPE);
                check($sformatf("vec%0d_result", i), bus.result_out, tbl[i].r);
                check($sformatf("vec%0d_ovf", i), bus.overflow, tbl[i].o);
            end else begin
                repeat (PIPE + 1) @(negedge clk);
                #1 check($sformatf("vec%0d_silent", i), bus.out_valid, 0);
            end
        end
        drain();

        for (int i = 0; i < 512; i++) send(16'h8000, 16'h8000, 1, 1, i == 511);
        k = 0;
        while (!bus.out_valid && k < PIPE + 4) begin
            @(negedge clk);
            #1 k++;
        end
        check("sat_result", bus.result_out, sat_r);
        check("sat_ovf", bus.overflow, sat_o);
        drain();

        mode = 1;
        c0 = consumed;
        for (int i = 0; i < 10; i++) send(16'(i), 16'd2, 0, 0, 0);
        drain();
        check("bp_count", 64'(consumed - c0), 10);

        mode = 2;
        for (int i = 0; i < 300; i++) begin
            logic [15:0] ra, rb;
            ra = ($urandom_range(3) == 0) ? 16'h8000 : 16'($urandom);
            rb = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
            send(ra, rb, 1'($urandom), $urandom_range(2) != 0, $urandom_range(3) == 0);
        end
        send(16'd1, 16'd1, 0, 1, 1);
        drain();

        mode = 0;
        send(16'd5, 16'd5, 0, 1, 0);
        send(16'd5, 16'd5, 0, 1, 0);
        @(negedge clk);
        reset = 1'b1;
        m_acc = '0;
        m_ovf = 1'b0;
        exp_q.delete();
        #1;
        check("mid_reset_valid", bus.out_valid, 0);
        check("mid_reset_result", bus.result_out, 0);
        check("mid_reset_ovf", bus.overflow, 0);
        @(negedge clk);
        #1 check("mid_reset_valid2", bus.out_valid, 0);
        reset = 1'b0;
        send(16'd7, 16'd7, 0, 1, 1);
        k = 0;
        while (!bus.out_valid && k < PIPE + 4) begin
            @(negedge clk);
            #1 k++;
        end
        check("post_reset_result", bus.result_out, 49);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
